// File: rtl/pmu_i2c_target_pkg.sv
// Shared definitions for the PMU I2C target and its controller-side users:
// protocol state encodings, the default PMU address and PMU subaddresses.
package pmu_i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_MACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

  localparam logic [6:0] PMU_I2C_ADDR   = 7'h34;

  localparam logic [7:0] PMU_SUB_ENABLE = 8'h10;
  localparam logic [7:0] PMU_SUB_SLEW   = 8'h20;
  localparam logic [7:0] PMU_SUB_DAC0   = 8'h23;
  localparam logic [7:0] PMU_SUB_DAC1   = 8'h26;
  localparam logic [7:0] PMU_SUB_DAC2   = 8'h29;
  localparam logic [7:0] PMU_SUB_DAC3   = 8'h32;

  // True when the 7-bit address field of an address byte selects this target.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr);
  endfunction

endpackage

// File: rtl/pmu_i2c_target_if.sv
// Host-side view of the PMU I2C target: register snoop, write notifications
// and status. The target uses the slave modport, the host the master modport.
interface pmu_i2c_target_if #(
  parameter int REG_AW = 6
);
  logic [REG_AW-1:0] host_rd_addr;
  logic [7:0]        host_rd_data;
  logic              wr_strobe;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic [7:0]        debug;

  modport slave (
    input  host_rd_addr,
    output host_rd_data, wr_strobe, wr_addr, wr_data, busy, debug
  );

  modport master (
    output host_rd_addr,
    input  host_rd_data, wr_strobe, wr_addr, wr_data, busy, debug
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Input conditioning for an SCL/SDA pair: 2-flop synchronizers, a
// consecutive-sample glitch filter, and single-cycle SCL edge and
// START/STOP pulses derived from the filtered levels.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0]            scl_sync_r;
  logic [1:0]            sda_sync_r;
  logic [FILTER_LEN-1:0] scl_hist_r;
  logic [FILTER_LEN-1:0] sda_hist_r;
  logic                  scl_filt_r;
  logic                  sda_filt_r;
  logic                  scl_prev_r;
  logic                  sda_prev_r;

  // Bring the asynchronous bus lines into the clk domain; idle bus is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
    end
  end

  // Sample history; a level only counts once it has been seen FILTER_LEN times.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist_r <= {FILTER_LEN{1'b1}};
      sda_hist_r <= {FILTER_LEN{1'b1}};
    end else begin
      scl_hist_r <= {scl_hist_r[FILTER_LEN-2:0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[FILTER_LEN-2:0], sda_sync_r[1]};
    end
  end

  // Filtered levels change only on a unanimous history, then get a delayed copy for edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      if (&scl_hist_r) begin
        scl_filt_r <= 1'b1;
      end else if (~|scl_hist_r) begin
        scl_filt_r <= 1'b0;
      end
      if (&sda_hist_r) begin
        sda_filt_r <= 1'b1;
      end else if (~|sda_hist_r) begin
        sda_filt_r <= 1'b0;
      end
      scl_prev_r <= scl_filt_r;
      sda_prev_r <= sda_filt_r;
    end
  end

  // START/STOP require SCL to have been high on both sides of the SDA edge.
  assign sda_filt  = sda_filt_r;
  assign scl_rise  = scl_filt_r & ~scl_prev_r;
  assign scl_fall  = ~scl_filt_r & scl_prev_r;
  assign start_det = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
  assign stop_det  = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;

endmodule

// File: rtl/pmu_i2c_target.sv
// I2C target emulating the PMU: address / subaddress / data write protocol,
// sequential reads from a pointer that survives STOP, a host snoop port and
// per-byte write notifications. SDA is open-drain (drives 0 or z only).
module pmu_i2c_target
  import pmu_i2c_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = PMU_I2C_ADDR,
  parameter int         REG_AW     = 6,
  parameter int         FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pmu_scl,
  inout  wire              pmu_sda,
  pmu_i2c_target_if.slave  host
);
  logic              sda_filt;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;

  i2c_state_e        state_r, state_n;
  logic [3:0]        cnt_r, cnt_n;
  logic [7:0]        shift_r, shift_n;
  logic [REG_AW-1:0] ptr_r, ptr_n;
  logic              drive_r, drive_n;
  logic              busy_r, busy_n;
  logic              wr_strobe_r, wr_strobe_n;
  logic [REG_AW-1:0] wr_addr_r, wr_addr_n;
  logic [7:0]        wr_data_r, wr_data_n;
  logic              hold_r;
  logic              sda_oe_r;
  logic [7:0]        regs_r [0:(2**REG_AW)-1];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (pmu_scl),
    .sda_in    (pmu_sda),
    .sda_filt  (sda_filt),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Next-state, pointer, shifter and SDA-request logic of the target protocol.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    shift_n     = shift_r;
    ptr_n       = ptr_r;
    drive_n     = drive_r;
    busy_n      = busy_r;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr_r;
    wr_data_n   = wr_data_r;
    if (stop_det) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
      drive_n = 1'b0;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = 4'd0;
      drive_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          drive_n = 1'b0;
          busy_n  = 1'b0;
        end
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shift_n = {shift_r[6:0], sda_filt};
            cnt_n   = cnt_r + 4'd1;
          end else if (scl_fall && (cnt_r == 4'd8)) begin
            cnt_n   = 4'd0;
            drive_n = 1'b1;
            case (state_r)
              ST_ADDR: begin
                if (addr_match(shift_r, I2C_ADDR)) begin
                  state_n = ST_ADDR_ACK;
                  busy_n  = 1'b1;
                end else begin
                  state_n = ST_IGNORE;
                  drive_n = 1'b0;
                end
              end
              ST_SUB: begin
                ptr_n   = shift_r[REG_AW-1:0];
                state_n = ST_SUB_ACK;
              end
              default: begin
                wr_strobe_n = 1'b1;
                wr_addr_n   = ptr_r;
                wr_data_n   = shift_r;
                ptr_n       = ptr_r + REG_AW'(1);
                state_n     = ST_WDATA_ACK;
              end
            endcase
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            cnt_n = 4'd0;
            if ((state_r == ST_ADDR_ACK) && shift_r[0]) begin
              shift_n = regs_r[ptr_r];
              drive_n = ~regs_r[ptr_r][7];
              state_n = ST_RDATA;
            end else if (state_r == ST_ADDR_ACK) begin
              drive_n = 1'b0;
              state_n = ST_SUB;
            end else begin
              drive_n = 1'b0;
              state_n = ST_WDATA;
            end
          end else begin
            drive_n = 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_n = cnt_r + 4'd1;
          end else if (scl_fall) begin
            if (cnt_r == 4'd8) begin
              drive_n = 1'b0;
              ptr_n   = ptr_r + REG_AW'(1);
              cnt_n   = 4'd0;
              state_n = ST_MACK;
            end else if (cnt_r == 4'd0) begin
              drive_n = ~shift_r[7];
            end else begin
              shift_n = {shift_r[6:0], 1'b0};
              drive_n = ~shift_r[6];
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (!sda_filt) begin
              shift_n = regs_r[ptr_r];
              cnt_n   = 4'd0;
              state_n = ST_RDATA;
            end else begin
              state_n = ST_IGNORE;
            end
          end else begin
            drive_n = 1'b0;
          end
        end
        ST_IGNORE: begin
          drive_n = 1'b0;
        end
        default: begin
          state_n = ST_IDLE;
          drive_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // Protocol state, datapath and notification registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      shift_r     <= 8'h00;
      ptr_r       <= '0;
      drive_r     <= 1'b0;
      busy_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 8'h00;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      shift_r     <= shift_n;
      ptr_r       <= ptr_n;
      drive_r     <= drive_n;
      busy_r      <= busy_n;
      wr_strobe_r <= wr_strobe_n;
      wr_addr_r   <= wr_addr_n;
      wr_data_r   <= wr_data_n;
    end
  end

  // SDA hold delay after SCL fall; START/STOP release the line at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r   <= 1'b0;
      sda_oe_r <= 1'b0;
    end else if (start_det || stop_det) begin
      hold_r   <= 1'b0;
      sda_oe_r <= 1'b0;
    end else begin
      hold_r   <= drive_r;
      sda_oe_r <= hold_r;
    end
  end

  // Register file; an I2C write lands the cycle after its wr_strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < (2**REG_AW); i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_strobe_r) begin
      regs_r[wr_addr_r] <= wr_data_r;
    end
  end

  assign pmu_sda           = sda_oe_r ? 1'b0 : 1'bz;
  assign host.host_rd_data = regs_r[host.host_rd_addr];
  assign host.wr_strobe    = wr_strobe_r;
  assign host.wr_addr      = wr_addr_r;
  assign host.wr_data      = wr_data_r;
  assign host.busy         = busy_r;
  assign host.debug        = {4'd0, state_r};

endmodule

// File: tb/tb_pmu_i2c_target.sv
// Directed bench for pmu_i2c_target: a bit-banged I2C master drives the bus,
// a transaction-level register/pointer model predicts ACKs, read data and
// write notifications, and a per-cycle process checks every wr_strobe.
module tb_pmu_i2c_target;
  import pmu_i2c_target_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic m_low;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  pmu_i2c_target_if #(.REG_AW(6)) host ();

  pmu_i2c_target #(.I2C_ADDR(7'h34), .REG_AW(6), .FILTER_LEN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .pmu_scl (scl),
    .pmu_sda (sda),
    .host    (host)
  );

  always #5 clk = ~clk;

  int          vectors      = 0;
  int          miscompares  = 0;
  int          strobes_seen = 0;
  logic [7:0]  mregs [64];
  logic [5:0]  mptr;
  logic [13:0] exp_q [$];
  logic [13:0] exp_e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Every write notification must match the next expected (addr, data).
  always @(negedge clk) begin
    if (host.wr_strobe === 1'b1) begin
      strobes_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_strobe_unexpected: got addr %h data %h, required no strobe",
                 host.wr_addr, host.wr_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 16'(host.wr_addr), 16'(exp_e[13:8]));
        check("wr_data", 16'(host.wr_data), 16'(exp_e[7:0]));
      end
    end
  end

  task automatic check_regs();
    for (int a = 0; a < 64; a++) begin
      host.host_rd_addr = 6'(a);
      @(negedge clk);
      check("host_rd_data", 16'(host.host_rd_data), 16'(mregs[a]));
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_low = 1'b0; wait_clk(2 * Q);
  endtask

  // One SCL period starting just after a fall; samples SDA and busy mid-high.
  task automatic clock_bit(input logic drive_low, output logic sampled, output logic busy_s);
    wait_clk(Q);
    m_low = drive_low; wait_clk(Q);
    scl   = 1'b1;      wait_clk(Q);
    @(negedge clk);
    sampled = sda;
    busy_s  = host.busy;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic busy_s);
    logic s, bs;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], s, bs);
    clock_bit(1'b0, s, busy_s);
    ack = (s === 1'b0);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s, bs;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b0, s, bs);
      b = {b[6:0], s};
    end
    clock_bit(master_ack, s, bs);
  endtask

  task automatic send_addr(input logic [7:0] ab);
    logic a, bs, hit;
    hit = (ab[7:1] == PMU_I2C_ADDR);
    write_byte(ab, a, bs);
    check("addr_ack", 16'(a), 16'(hit));
    check("addr_busy", 16'(bs), 16'(hit));
  endtask

  task automatic write_txn(input logic [7:0] sub, input int n,
                           input logic [7:0] d0, input logic [7:0] d1);
    logic a, bs;
    logic [7:0] d;
    i2c_start();
    send_addr(8'h68);
    write_byte(sub, a, bs);
    check("sub_ack", 16'(a), 16'(1'b1));
    mptr = sub[5:0];
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      exp_q.push_back({mptr, d});
      mregs[mptr] = d;
      mptr = mptr + 6'd1;
      write_byte(d, a, bs);
      check("wdata_ack", 16'(a), 16'(1'b1));
    end
    i2c_stop();
    check("strobes_pending", 16'(exp_q.size()), 16'(0));
  endtask

  task automatic read_txn(input int n, output logic [7:0] first, output logic [7:0] second);
    logic [7:0] b;
    first  = 8'h00;
    second = 8'h00;
    i2c_start();
    send_addr(8'h69);
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, b);
      check("read_data", 16'(b), 16'(mregs[mptr]));
      mptr = mptr + 6'd1;
      if (k == 0) first = b; else second = b;
    end
    wait_clk(Q);
    check("sda_released_after_nack", 16'(sda), 16'(1'b1));
    i2c_stop();
  endtask

  initial begin
    logic [7:0] b0, b1;
    logic s, bs;
    int s0;
    scl = 1'b1;
    m_low = 1'b0;
    host.host_rd_addr = 6'h00;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    mptr = 6'h00;
    wait_clk(5);
    @(negedge clk);
    check("rst_debug", 16'(host.debug), 16'(8'h00));
    check("rst_busy", 16'(host.busy), 16'(1'b0));
    check("rst_wr_strobe", 16'(host.wr_strobe), 16'(1'b0));
    check("rst_sda", 16'(sda), 16'(1'b1));
    reset = 1'b1;
    wait_clk(5);
    check_regs();

    // Single write to the enable register.
    s0 = strobes_seen;
    write_txn(PMU_SUB_ENABLE, 1, 8'hA5, 8'h00);
    check("t1_strobe_count", 16'(strobes_seen - s0), 16'(1));
    host.host_rd_addr = 6'h10;
    @(negedge clk);
    check("t1_host_10", 16'(host.host_rd_data), 16'(8'hA5));

    // Write then read from the post-incremented pointer; pointer persistence.
    write_txn(8'h21, 1, 8'h55, 8'h00);
    write_txn(PMU_SUB_SLEW, 1, 8'h55, 8'h00);
    read_txn(1, b0, b1);
    check("t2_read_21", 16'(b0), 16'(8'h55));
    write_txn(PMU_SUB_DAC3, 1, 8'hC3, 8'h00);
    write_txn(PMU_SUB_DAC3, 0, 8'h00, 8'h00);
    read_txn(1, b0, b1);
    check("t2_read_32", 16'(b0), 16'(8'hC3));

    // Burst write wrapping from the last register to 0.
    s0 = strobes_seen;
    write_txn(8'h3F, 2, 8'h11, 8'h22);
    check("t3_strobe_count", 16'(strobes_seen - s0), 16'(2));
    host.host_rd_addr = 6'h3F;
    @(negedge clk);
    check("t3_host_3f", 16'(host.host_rd_data), 16'(8'h11));
    host.host_rd_addr = 6'h00;
    @(negedge clk);
    check("t3_host_00", 16'(host.host_rd_data), 16'(8'h22));
    check_regs();

    // Foreign address: no ACK, never busy, registers untouched.
    i2c_start();
    send_addr(8'h6A);
    i2c_stop();
    check("t4_busy_after", 16'(host.busy), 16'(1'b0));
    check_regs();
    write_txn(8'h05, 1, 8'h77, 8'h00);

    // Two-byte read with master ACK then NACK.
    write_txn(PMU_SUB_ENABLE, 2, 8'hA5, 8'h3C);
    write_txn(PMU_SUB_ENABLE, 0, 8'h00, 8'h00);
    read_txn(2, b0, b1);
    check("t5_read_first", 16'(b0), 16'(8'hA5));
    check("t5_read_second", 16'(b1), 16'(8'h3C));

    // One-clock SDA glitch while SCL high must not look like START/STOP.
    @(posedge clk); m_low = 1'b1;
    @(posedge clk); m_low = 1'b0;
    wait_clk(20);
    check("t5_glitch_state", 16'(host.debug), 16'(8'h00));
    check("t5_glitch_busy", 16'(host.busy), 16'(1'b0));

    // Asynchronous reset while the target drives a 0 during a read.
    write_txn(8'h07, 1, 8'h0F, 8'h00);
    write_txn(8'h07, 0, 8'h00, 8'h00);
    i2c_start();
    send_addr(8'h69);
    clock_bit(1'b0, s, bs);
    check("t6_bit7", 16'(s), 16'(1'b0));
    clock_bit(1'b0, s, bs);
    check("t6_bit6", 16'(s), 16'(1'b0));
    wait_clk(Q);
    check("t6_driving_low", 16'(sda), 16'(1'b0));
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_release", 16'(sda), 16'(1'b1));
    check("t6_async_state", 16'(host.debug), 16'(8'h00));
    for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    mptr = 6'h00;
    exp_q.delete();
    scl = 1'b1;
    m_low = 1'b0;
    wait_clk(5);
    check_regs();
    reset = 1'b1;
    wait_clk(10);
    write_txn(8'h05, 1, 8'h99, 8'h00);
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
